// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall scheduler for the 5-stage MIPS pipeline. It merges the ID
//   load-use request and the EX multi-cycle request into the shared stall bus.
//   It also owns the ID-stage instruction hold buffer, keeps per-cause stall
//   counters and raises a sticky watchdog flag when EX stays busy too long.
//
//   The instruction SRAM is synchronous and re-reads the held PC while the
//   pipeline is stalled. For that reason, the instruction sitting in ID is
//   captured once when a stall begins and replayed until the stall releases.
//
// Ports
//   clk             in   clock
//   rst             in   synchronous, active-high reset
//   stallreq_id     in   load-use hazard request from ID
//   stallreq_ex     in   multi-cycle busy request from EX
//   inst_sram_rdata in   [31:0] SRAM read data (one cycle after the address)
//   stall           out  [STALL_WD-1:0] stall bus
//                        bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
//                        1 = stop
//   id_inst         out  [31:0] instruction that ID decodes this cycle
//   inst_held       out  1 = id_inst comes from the hold buffer
//   cnt_id_stall    out  [CNT_WD-1:0] cycles stalled by the ID cause
//   cnt_ex_stall    out  [CNT_WD-1:0] cycles stalled by the EX cause
//   ex_timeout_err  out  sticky flag: EX stalled EX_TIMEOUT consecutive cycles
// -----------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int STALL_WD   = 6,
  parameter int CNT_WD     = 32,
  parameter int EX_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic [31:0]         inst_sram_rdata,
  output logic [STALL_WD-1:0] stall,
  output logic [31:0]         id_inst,
  output logic                inst_held,
  output logic [CNT_WD-1:0]   cnt_id_stall,
  output logic [CNT_WD-1:0]   cnt_ex_stall,
  output logic                ex_timeout_err
);

  // EX stall freezes PC..EX and sends a bubble into MEM. ID stall freezes
  // PC..ID and sends a bubble into EX.
  localparam logic [STALL_WD-1:0] STALL_EX = STALL_WD'(6'b001111);
  localparam logic [STALL_WD-1:0] STALL_ID = STALL_WD'(6'b000111);

  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

  // The run counter must be able to hold the value EX_TIMEOUT, where it saturates.
  localparam int                RUN_WD   = $clog2(EX_TIMEOUT + 1);
  localparam logic [RUN_WD-1:0] RUN_MAX  = RUN_WD'(EX_TIMEOUT);
  localparam logic [RUN_WD-1:0] RUN_LAST = RUN_WD'(EX_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

  hold_state_e       state, state_nxt;
  logic [31:0]       hold_buf;
  logic              capture;
  logic [RUN_WD-1:0] ex_run_cnt;

  // ---------------------------------------------------------------------------
  // Stall bus encoding: EX has priority over ID. The bus is forced quiet
  // during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // without it, a path that skips an assignment would infer a latch.
    stall = '0;
    if (!rst) begin
      if (stallreq_ex)      stall = STALL_EX;
      else if (stallreq_id) stall = STALL_ID;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold FSM: next state and output mux
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    id_inst   = inst_sram_rdata;
    inst_held = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (stall[2]) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The release cycle (stall[2] low) still replays the buffer. Live
        // SRAM data becomes valid only one cycle later, once the SRAM has
        // re-read the held IF PC.
        id_inst   = hold_buf;
        inst_held = 1'b1;
        if (!stall[2]) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs as they were before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // The buffer is written only on the RUN->HOLD transition. A change of
  // cause while in HOLD therefore leaves the instruction originally in ID
  // intact.
  always_ff @(posedge clk) begin
    // NOTE: this storage is cleared on reset on purpose, so that a replay
    // after reset can never present stale data. Pure data storage that is
    // always written before use would normally be left without a reset.
    if (rst)          hold_buf <= '0;
    else if (capture) hold_buf <= inst_sram_rdata;
  end

  // ---------------------------------------------------------------------------
  // Per-cause performance counters (wrap modulo 2^CNT_WD)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_id_stall <= '0;
      cnt_ex_stall <= '0;
    end else begin
      if (stallreq_ex)      cnt_ex_stall <= cnt_ex_stall + CNT_ONE;
      else if (stallreq_id) cnt_id_stall <= cnt_id_stall + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // EX watchdog. ex_run_cnt holds the number of consecutive EX-stall cycles
  // before the current one. The flag therefore sets at the edge that ends
  // the EX_TIMEOUT-th such cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_run_cnt     <= '0;
      ex_timeout_err <= 1'b0;
    end else begin
      if (!stallreq_ex)            ex_run_cnt <= '0;
      else if (ex_run_cnt != RUN_MAX) ex_run_cnt <= ex_run_cnt + RUN_WD'(1);

      if (stallreq_ex && (ex_run_cnt >= RUN_LAST)) ex_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//   Table-driven bench for pipe_stall_ctrl (CNT_WD = 4, EX_TIMEOUT = 4).
//   Each record holds one cycle's inputs together with the outputs expected
//   in that same cycle. The records are queued when applied and compared
//   mid-cycle, on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int STALL_WD = 6;
  localparam int CNT_WD   = 4;
  localparam int EX_TO    = 4;

  logic                clk;
  logic                rst;
  logic                stallreq_id;
  logic                stallreq_ex;
  logic [31:0]         inst_sram_rdata;
  logic [STALL_WD-1:0] stall;
  logic [31:0]         id_inst;
  logic                inst_held;
  logic [CNT_WD-1:0]   cnt_id_stall;
  logic [CNT_WD-1:0]   cnt_ex_stall;
  logic                ex_timeout_err;

  pipe_stall_ctrl #(
    .STALL_WD  (STALL_WD),
    .CNT_WD    (CNT_WD),
    .EX_TIMEOUT(EX_TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .inst_sram_rdata(inst_sram_rdata),
    .stall          (stall),
    .id_inst        (id_inst),
    .inst_held      (inst_held),
    .cnt_id_stall   (cnt_id_stall),
    .cnt_ex_stall   (cnt_ex_stall),
    .ex_timeout_err (ex_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                rst;
    logic                id;
    logic                ex;
    logic [31:0]         rdata;
    logic [STALL_WD-1:0] stall;
    logic [31:0]         inst;
    logic                held;
    logic [CNT_WD-1:0]   cid;
    logic [CNT_WD-1:0]   cex;
    logic                err;
  } vec_t;

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] SID = 6'b000111;
  localparam logic [5:0] SEX = 6'b001111;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(logic r, logic i, logic e, logic [31:0] rd,
                              logic [5:0] s, logic [31:0] inst, logic h,
                              int cid, int cex, logic err);
    vec_t v;
    v.rst = r;  v.id = i;  v.ex = e;  v.rdata = rd;
    v.stall = s;  v.inst = inst;  v.held = h;
    v.cid = CNT_WD'(cid);  v.cex = CNT_WD'(cex);  v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_cycle(input int idx);
    vec_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d: scoreboard empty", idx);
      return;
    end
    e = sb_q.pop_front();
    check($sformatf("v%0d stall", idx),     32'(stall),          32'(e.stall));
    check($sformatf("v%0d id_inst", idx),   id_inst,             e.inst);
    check($sformatf("v%0d inst_held", idx), 32'(inst_held),      32'(e.held));
    check($sformatf("v%0d cnt_id", idx),    32'(cnt_id_stall),   32'(e.cid));
    check($sformatf("v%0d cnt_ex", idx),    32'(cnt_ex_stall),   32'(e.cex));
    check($sformatf("v%0d err", idx),       32'(ex_timeout_err), 32'(e.err));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with both requests high: the stall bus must stay quiet.
    vecs.push_back(mk(1, 1, 1, 32'h1111_1111, S0,  32'h1111_1111, 0, 0, 0, 0));
    // Single load-use stall
    vecs.push_back(mk(0, 0, 0, 32'h0000_0001, S0,  32'h0000_0001, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h8C22_0004, SID, 32'h8C22_0004, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0043_2021, S0,  32'h8C22_0004, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0000_0002, S0,  32'h0000_0002, 0, 1, 0, 0));
    // EX stall for 3 cycles with ID also requesting: EX wins, one capture
    vecs.push_back(mk(0, 1, 1, 32'hAAAA_0001, SEX, 32'hAAAA_0001, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'hAAAA_0002, SEX, 32'hAAAA_0001, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'hAAAA_0003, SEX, 32'hAAAA_0001, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 32'hAAAA_0004, S0,  32'hAAAA_0001, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 32'hAAAA_0005, S0,  32'hAAAA_0005, 0, 1, 3, 0));
    // Cause switch EX -> ID -> idle
    vecs.push_back(mk(0, 0, 1, 32'hBBBB_0001, SEX, 32'hBBBB_0001, 0, 1, 3, 0));
    vecs.push_back(mk(0, 1, 0, 32'hBBBB_0002, SID, 32'hBBBB_0001, 1, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 32'hBBBB_0003, S0,  32'hBBBB_0001, 1, 2, 4, 0));
    vecs.push_back(mk(0, 0, 0, 32'hBBBB_0004, S0,  32'hBBBB_0004, 0, 2, 4, 0));
    // Watchdog: EX for 3 cycles, idle 1, EX for 4 cycles, then idle
    vecs.push_back(mk(0, 0, 1, 32'hC000_0001, SEX, 32'hC000_0001, 0, 2, 4, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC000_0002, SEX, 32'hC000_0001, 1, 2, 5, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC000_0003, SEX, 32'hC000_0001, 1, 2, 6, 0));
    vecs.push_back(mk(0, 0, 0, 32'hC000_0004, S0,  32'hC000_0001, 1, 2, 7, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC000_0005, SEX, 32'hC000_0005, 0, 2, 7, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC000_0006, SEX, 32'hC000_0005, 1, 2, 8, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC000_0007, SEX, 32'hC000_0005, 1, 2, 9, 0));
    vecs.push_back(mk(0, 0, 1, 32'hC000_0008, SEX, 32'hC000_0005, 1, 2, 10, 0));
    vecs.push_back(mk(0, 0, 0, 32'hC000_0009, S0,  32'hC000_0005, 1, 2, 11, 1));
    vecs.push_back(mk(0, 0, 0, 32'hC000_000A, S0,  32'hC000_000A, 0, 2, 11, 1));
    // Reset pulsed while in HOLD with nonzero counters and the flag set
    vecs.push_back(mk(0, 1, 0, 32'hD000_0001, SID, 32'hD000_0001, 0, 2, 11, 1));
    vecs.push_back(mk(1, 1, 1, 32'hD000_0002, S0,  32'hD000_0001, 1, 3, 11, 1));
    vecs.push_back(mk(0, 0, 0, 32'hD000_0003, S0,  32'hD000_0003, 0, 0, 0, 0));
    // Counter wrap: 17 ID-stall cycles leave cnt_id_stall = 1 (mod 16)
    for (int i = 0; i < 17; i++)
      vecs.push_back(mk(0, 1, 0, 32'hE000_0000 + 32'(i), SID, 32'hE000_0000,
                        (i != 0), i % 16, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'hF000_0000, S0,  32'hE000_0000, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'hF000_0001, S0,  32'hF000_0001, 0, 1, 0, 0));
    // Back-to-back: a stall right after a release captures fresh data
    vecs.push_back(mk(0, 1, 0, 32'h1234_0001, SID, 32'h1234_0001, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h1234_0002, S0,  32'h1234_0001, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h1234_0003, SID, 32'h1234_0003, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h1234_0004, S0,  32'h1234_0003, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h1234_0005, S0,  32'h1234_0005, 0, 3, 0, 0));

    rst             = 1'b1;
    stallreq_id     = 1'b0;
    stallreq_ex     = 1'b0;
    inst_sram_rdata = '0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk);
      #1;
      rst             = vecs[k].rst;
      stallreq_id     = vecs[k].id;
      stallreq_ex     = vecs[k].ex;
      inst_sram_rdata = vecs[k].rdata;
      sb_q.push_back(vecs[k]);
      @(negedge clk);
      compare_cycle(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline stall scheduler for the 5-stage MIPS core (PC, IF, ID, EX, MEM, WB).
- Merges stall requests from ID (load-use) and EX (multi-cycle ops) into the shared stall bus.
- Owns the ID-stage instruction hold buffer. The synchronous inst SRAM re-reads the held PC during a stall, so the instruction in ID must be captured once and replayed until the stall releases.
- Keeps per-cause stall counters and a sticky watchdog flag for a hung EX stall.

Parameters:
- STALL_WD, 6: stall bus width. Bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. 1 = Stop.
- CNT_WD, 32: width of the stall performance counters.
- EX_TIMEOUT, 64: number of consecutive stallreq_ex cycles that sets the watchdog flag; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stallreq_id  in  1  load-use hazard request from ID.
- stallreq_ex  in  1  multi-cycle busy request from EX.
- inst_sram_rdata  in  32  instruction SRAM read data, one cycle after address.
- stall  out  STALL_WD  stall bus to all stage registers.
- id_inst  out  32  instruction ID must decode this cycle.
- inst_held  out  1  1 = id_inst is sourced from the hold buffer.
- cnt_id_stall  out  CNT_WD  cycles stalled by ID cause.
- cnt_ex_stall  out  CNT_WD  cycles stalled by EX cause.
- ex_timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Stall encoding is combinational from the current inputs:
  - stallreq_ex = 1 gives 6'b001111: PC, IF, ID and EX hold; MEM receives a bubble.
  - Otherwise stallreq_id = 1 gives 6'b000111: PC, IF and ID hold; EX receives a bubble.
  - Otherwise 6'b000000.
  - stallreq_ex has priority; stallreq_id is ignored for classification while stallreq_ex is high.
  - While rst = 1, stall = 0.
- Hold FSM has two states, RUN and HOLD; reset state is RUN.
- In RUN:
  - id_inst = inst_sram_rdata, inst_held = 0.
  - If stall[2] = 1 this cycle: capture inst_sram_rdata into hold_buf at the clock edge and go to HOLD.
- In HOLD:
  - id_inst = hold_buf, inst_held = 1.
  - hold_buf is not rewritten in HOLD, even if the stall cause switches between ID and EX.
  - Stay in HOLD while stall[2] = 1.
  - At the edge of the first cycle with stall[2] = 0, go to RUN. That release cycle still presents hold_buf.
  - The following cycle uses live SRAM data, which is valid because the SRAM re-read the held IF PC.
- Back-to-back stalls: a RUN cycle with stall[2] = 1 immediately after a release captures fresh data as normal.
- Counters: reset to 0; both advance at the edge ending the counted cycle.
  - cnt_ex_stall increments each cycle stallreq_ex = 1.
  - cnt_id_stall increments each cycle stallreq_id = 1 and stallreq_ex = 0.
  - Both wrap modulo 2^CNT_WD with no saturation.
- Watchdog:
  - An internal run counter increments while stallreq_ex = 1, saturates at EX_TIMEOUT, and clears to 0 in any cycle with stallreq_ex = 0.
  - ex_timeout_err sets at the edge ending the EX_TIMEOUT-th consecutive stallreq_ex cycle.
  - It stays set until rst; stall behaviour is unaffected.
- Reset at any point, including mid-HOLD, applies at the next edge:
  - state = RUN, hold_buf = 0, all counters = 0, ex_timeout_err = 0.
  - inst_held = 0 in the cycle after the reset edge.
- Outputs are glitch-free functions of registered state plus the current request inputs. There are no other combinational paths from inst_sram_rdata except the id_inst mux in RUN.

Test Plan:
- Single load-use: stallreq_id high for cycle 5 only, rdata = 0x8C220004 in cycle 5, 0x00432021 in cycle 6.
  - Cycle 5: stall = 000111, id_inst = 0x8C220004.
  - Cycle 6: inst_held = 1, id_inst = 0x8C220004, stall = 0.
  - Cycle 7: inst_held = 0, id_inst = live rdata.
  - cnt_id_stall = 1.
- EX stall 3 cycles with stallreq_id also high in all three: stall = 001111 for 3 cycles.
  - hold_buf captured once, in the first cycle.
  - cnt_ex_stall = 3, cnt_id_stall = 0.
- Cause switch: cycle 1 stallreq_ex, cycle 2 stallreq_id only, cycle 3 idle.
  - stall = 001111, then 000111, then 0.
  - hold_buf keeps the cycle-1 data through cycle 3; RUN from cycle 4.
- Watchdog with EX_TIMEOUT = 4: stallreq_ex high for 3 cycles, low 1, high 4.
  - No flag after the first burst.
  - ex_timeout_err = 1 after the 4th cycle of the second burst; remains 1 after the request drops.
- Reset mid-HOLD: rst pulsed for 1 cycle while in HOLD with counters nonzero.
  - Next cycle: inst_held = 0, counters = 0, err = 0, stall = 0 during rst.
- Counter wrap with CNT_WD = 4: 17 ID-stall cycles leave cnt_id_stall = 1.
